frame_pattern_writer: RTL and testbench

FRAME_PATTERN_WRITER -- requirements
Module: frame_pattern_writer

---
 rtl/frame_pattern_writer.sv | 188 ++++++++++++++++++
 tb/tb_frame_pattern_writer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pattern_writer.sv
// Wishbone master that writes one test-pattern frame per start request.
// Pixels go out in raster order; the bus is released for one cycle after
// every BURST_LEN acknowledged writes. A slave error aborts the frame and
// sets a sticky error flag. A retry repeats the same write on the next cycle.
module frame_pattern_writer #(
    parameter int HDISP     = 800,
    parameter int VDISP     = 480,
    parameter int BURST_LEN = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic        wshb_we,
    output logic [31:0] wshb_adr,
    output logic [31:0] wshb_dat_ms,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    input  logic        wshb_ack,
    input  logic        wshb_err,
    input  logic        wshb_rty,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  frame_cnt
);

    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [31:0] HDISP_U = HDISP;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_PAUSE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [BW-1:0]   r_bcnt;
    logic [1:0]      r_mode;
    logic            r_done;
    logic            r_error;
    logic [7:0]      r_frame_cnt;

    logic            w_active;
    logic            w_last_x;
    logic            w_last_pix;
    logic [BW-1:0]   w_bcnt_inc;
    logic            w_burst_full;
    logic [31:0]     w_adr;
    logic [2:0]      w_bar;
    logic            w_grid;
    logic [23:0]     w_rgb;

    assign w_active     = (r_state == S_BURST);
    assign w_last_x     = (r_x == XW'(HDISP - 1));
    assign w_last_pix   = w_last_x && (r_y == YW'(VDISP - 1));
    assign w_bcnt_inc   = r_bcnt + BW'(1);
    assign w_burst_full = (w_bcnt_inc == BW'(BURST_LEN));

    // Byte address and pattern are pure functions of registered state, so the
    // bus outputs hold steady across wait states and retries.
    assign w_adr  = (32'(r_y) * HDISP_U + 32'(r_x)) << 2;
    assign w_bar  = 3'((32'(r_x) * 32'd8) / HDISP_U);
    assign w_grid = ((32'(r_x) & 32'hF) == 32'd0) || ((32'(r_y) & 32'hF) == 32'd0);

    // Pattern generator driven by the mode latched at frame start.
    always_comb begin
        w_rgb = '0;
        unique case (r_mode)
            2'd0:    w_rgb = w_grid ? 24'hFFFFFF : 24'h000000;
            2'd1:    w_rgb = {{8{w_bar[2]}}, {8{w_bar[1]}}, {8{w_bar[0]}}};
            2'd2:    w_rgb = {8'(r_x), 8'(r_y), r_frame_cnt};
            default: w_rgb = 24'hFFFFFF;
        endcase
    end

    // cyc/stb decode from the state register only: no path from slave inputs.
    assign wshb_cyc    = w_active;
    assign wshb_stb    = w_active;
    assign wshb_we     = w_active;
    assign wshb_sel    = w_active ? 4'hF : '0;
    assign wshb_cti    = '0;
    assign wshb_bte    = '0;
    assign wshb_adr    = w_active ? w_adr : '0;
    assign wshb_dat_ms = w_active ? {8'h00, w_rgb} : '0;

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign error     = r_error;
    assign frame_cnt = r_frame_cnt;

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; err beats ack, ack beats rty.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_BURST;
                end
            end
            S_BURST: begin
                if (wshb_err) begin
                    w_next = S_IDLE;
                end else if (wshb_ack) begin
                    if (w_last_pix) begin
                        w_next = S_IDLE;
                    end else if (w_burst_full) begin
                        w_next = S_PAUSE;
                    end
                end else if (wshb_rty) begin
                    w_next = S_BURST;
                end
            end
            S_PAUSE: begin
                w_next = S_BURST;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Pixel counters, burst counter, mode latch and status flags.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_bcnt      <= '0;
            r_mode      <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x    <= '0;
                        r_y    <= '0;
                        r_bcnt <= '0;
                        r_mode <= mode;
                    end
                end
                S_BURST: begin
                    if (wshb_err) begin
                        r_error <= 1'b1;
                    end else if (wshb_ack) begin
                        if (w_last_pix) begin
                            r_x         <= '0;
                            r_y         <= '0;
                            r_bcnt      <= '0;
                            r_done      <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end else begin
                            if (w_last_x) begin
                                r_x <= '0;
                                r_y <= r_y + YW'(1);
                            end else begin
                                r_x <= r_x + XW'(1);
                            end
                            r_bcnt <= w_burst_full ? '0 : w_bcnt_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_pattern_writer.sv
// Directed bench for frame_pattern_writer with a small 16x4 frame, bursts of 8.
// A behavioural Wishbone slave with configurable wait states, one-shot retry
// and one-shot error records every acknowledged write for later comparison.
module tb_frame_pattern_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic        cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack, err, rty;
    logic        busy, done, error;
    logic [7:0]  frame_cnt;

    frame_pattern_writer #(
        .HDISP(16),
        .VDISP(4),
        .BURST_LEN(8)
    ) dut (
        .sys_clk(clk),
        .sys_rst_n(rst_n),
        .start(start),
        .mode(mode),
        .wshb_cyc(cyc),
        .wshb_stb(stb),
        .wshb_we(we),
        .wshb_adr(adr),
        .wshb_dat_ms(dat),
        .wshb_sel(sel),
        .wshb_cti(cti),
        .wshb_bte(bte),
        .wshb_ack(ack),
        .wshb_err(err),
        .wshb_rty(rty),
        .busy(busy),
        .done(done),
        .error(error),
        .frame_cnt(frame_cnt)
    );

    int n_total = 0;
    int n_bad   = 0;

    // slave / monitor state
    logic [31:0] wr_adr [0:255];
    logic [31:0] wr_dat [0:255];
    int          n_wr;
    int          dly_max;
    int          wait_left;
    bit          pending;
    logic [31:0] hold_adr, hold_dat;
    int          viol;
    int          pause_cnt, pause_bad;
    bit          prev_pause;
    int          done_cnt;
    bit          rty_en, err_en, rty_chk;
    logic [31:0] rty_adr, err_adr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_dat(input logic [1:0] m, input int i, input logic [7:0] fc);
        logic [7:0] x, y;
        logic [2:0] b;
        x = 8'(i % 16);
        y = 8'(i / 16);
        b = 3'((int'(x) * 8) / 16);
        case (m)
            2'd0:    exp_dat = ((x % 16) == 0 || (y % 16) == 0) ? 32'h00FFFFFF : 32'h0;
            2'd1:    exp_dat = {8'h00, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
            2'd2:    exp_dat = {8'h00, x, y, fc};
            default: exp_dat = 32'h00FFFFFF;
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave response and protocol monitor, all at the falling edge.
    initial begin
        ack = 0; err = 0; rty = 0;
        pending = 0; prev_pause = 0; wait_left = 0;
        forever begin
            @(negedge clk);
            ack = 0; err = 0; rty = 0;
            if (!rst_n) begin
                pending = 0;
                prev_pause = 0;
                continue;
            end
            if (done) done_cnt++;
            if (busy && !cyc) begin
                pause_cnt++;
                if ((n_wr % 8) != 0 || prev_pause) pause_bad++;
                prev_pause = 1;
            end else begin
                prev_pause = 0;
            end
            if (cyc && stb) begin
                if (rty_chk) begin
                    chk("rty_reissue", adr, rty_adr);
                    rty_chk = 0;
                end
                if (pending) begin
                    if (adr !== hold_adr || dat !== hold_dat) viol++;
                end else begin
                    pending   = 1;
                    hold_adr  = adr;
                    hold_dat  = dat;
                    wait_left = (dly_max > 0) ? int'($urandom_range(dly_max, 0)) : 0;
                end
                if (!we || sel !== 4'hF || cti !== 3'b000 || bte !== 2'b00) viol++;
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    pending = 0;
                    if (err_en && adr == err_adr) begin
                        err = 1;
                        err_en = 0;
                    end else if (rty_en && adr == rty_adr) begin
                        rty = 1;
                        rty_en = 0;
                        rty_chk = 1;
                    end else begin
                        ack = 1;
                        if (n_wr < 256) begin
                            wr_adr[n_wr] = adr;
                            wr_dat[n_wr] = dat;
                        end
                        n_wr++;
                    end
                end
            end else begin
                pending = 0;
            end
        end
    end

    task automatic start_frame(input logic [1:0] m, input int dly, input bit rel);
        n_wr = 0; pause_cnt = 0; pause_bad = 0; done_cnt = 0; viol = 0;
        dly_max = dly;
        mode  = m;
        start = 1;
        if (rel) rst_n = 1;
        @(negedge clk);
        start = 0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle(input bit poke, input logic [1:0] m);
        bit fin;
        fin = 0;
        for (int c = 0; c < 3000; c++) begin
            if (poke && c == 20) begin
                start = 1;
                mode  = ~m;
            end
            if (poke && c == 21) start = 0;
            if (!busy) begin
                fin = 1;
                break;
            end
            @(negedge clk);
        end
        start = 0;
        chk("frame_end", {31'd0, fin}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input logic [1:0] m, input logic [7:0] fc);
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (wr_adr[i] !== 32'(4 * i) || wr_dat[i] !== exp_dat(m, i, fc)) bad++;
        end
        chk({tag, "_writes"}, n_wr, 64);
        chk({tag, "_content"}, bad, 0);
        chk({tag, "_done"}, done_cnt, 1);
    endtask

    initial begin
        rst_n = 0; start = 0; mode = 0;
        rty_en = 0; err_en = 0; rty_chk = 0;
        rty_adr = 32'h10; err_adr = 32'h20;
        dly_max = 0; n_wr = 0; viol = 0; done_cnt = 0;
        pause_cnt = 0; pause_bad = 0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", {31'd0, cyc}, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", dat, 0);
        chk("rst_sel_busy_done_err", {sel, busy, done, error}, 0);
        chk("rst_fcnt", frame_cnt, 0);

        // solid frame, ack every cycle; start on the very first edge after release
        start_frame(2'd3, 0, 1);
        wait_idle(0, 2'd3);
        check_frame("solid", 2'd3, 8'd0);
        chk("solid_pauses", pause_cnt, 7);
        chk("solid_pause_shape", pause_bad, 0);
        chk("solid_fcnt", frame_cnt, 1);

        // grid with random wait states
        start_frame(2'd0, 5, 0);
        wait_idle(0, 2'd0);
        check_frame("grid", 2'd0, 8'd0);
        chk("grid_stable", viol, 0);
        chk("grid_px11", wr_dat[17], 32'h0);
        chk("grid_px01", wr_dat[16], 32'h00FFFFFF);
        chk("grid_fcnt", frame_cnt, 2);

        // colour bars
        start_frame(2'd1, 0, 0);
        wait_idle(0, 2'd1);
        check_frame("bars", 2'd1, 8'd0);

        // one retry on 0x10
        rty_en = 1;
        start_frame(2'd3, 0, 0);
        wait_idle(0, 2'd3);
        check_frame("rty", 2'd3, 8'd0);
        chk("rty_fired", {31'd0, rty_en}, 0);
        chk("rty_pause_shape", pause_bad, 0);
        chk("rty_fcnt", frame_cnt, 4);

        // error on 0x20 aborts
        err_en = 1;
        start_frame(2'd3, 0, 0);
        wait_idle(0, 2'd3);
        chk("err_writes", n_wr, 8);
        chk("err_flag", {31'd0, error}, 1);
        chk("err_no_done", done_cnt, 0);
        chk("err_fcnt", frame_cnt, 4);
        start_frame(2'd3, 0, 0);
        wait_idle(0, 2'd3);
        check_frame("after_err", 2'd3, 8'd0);
        chk("err_sticky", {31'd0, error}, 1);
        chk("after_err_fcnt", frame_cnt, 5);

        // reset during the third burst
        start_frame(2'd3, 0, 0);
        for (int c = 0; c < 500; c++) begin
            if (n_wr >= 18) break;
            @(negedge clk);
        end
        chk("reach_burst3", {31'd0, (n_wr >= 18)}, 1);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_cyc_stb_we", {29'd0, cyc, stb, we}, 0);
        chk("arst_adr", adr, 0);
        chk("arst_dat", dat, 0);
        chk("arst_flags", {sel, busy, done, error}, 0);
        chk("arst_fcnt", frame_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        chk("no_resume", {30'd0, cyc, busy}, 0);

        // two gradient frames; mid-frame start and mode change are ignored
        start_frame(2'd2, 0, 0);
        wait_idle(1, 2'd2);
        check_frame("grad1", 2'd2, 8'd0);
        start_frame(2'd2, 0, 0);
        wait_idle(1, 2'd2);
        check_frame("grad2", 2'd2, 8'd1);
        chk("grad_fcnt", frame_cnt, 2);
        chk("grad_idle", {31'd0, busy}, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
